// File: rtl/debouncer_bank.sv
// debouncer_bank: per-channel synchronizer + stability counter + FSM.
// Ports: CLK, reset (sync, active-high), enable (0 = bypass), in[CHANNELS] raw inputs,
//        out[CHANNELS] clean levels, rise/fall[CHANNELS] 1-cycle pulses, changed = OR of pulses.
module debouncer_bank #(
    parameter int   CHANNELS    = 4,
    parameter int   WAIT_BITS   = 8,
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                enable,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                changed
);

    typedef enum logic {
        STABLE,
        COUNTING
    } state_t;

    localparam logic [WAIT_BITS-1:0] CNT_MAX = '1;
    localparam logic [WAIT_BITS-1:0] CNT_ONE = WAIT_BITS'(1);

    logic [SYNC_STAGES-1:0] sync_q  [CHANNELS];
    state_t                 state_q [CHANNELS];
    state_t                 state_d [CHANNELS];
    logic [WAIT_BITS-1:0]   cnt_q   [CHANNELS];
    logic [WAIT_BITS-1:0]   cnt_d   [CHANNELS];
    logic [CHANNELS-1:0]    s;
    logic [CHANNELS-1:0]    out_d;
    logic [CHANNELS-1:0]    rise_d;
    logic [CHANNELS-1:0]    fall_d;

    always_comb begin
        s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            s[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    always_comb begin
        out_d = out;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (!enable) begin
                // Bypass: follow the synchronized input, drop any count.
                out_d[i]   = s[i];
                state_d[i] = STABLE;
                cnt_d[i]   = '0;
            end else begin
                unique case (state_q[i])
                    STABLE: begin
                        cnt_d[i] = '0;
                        if (s[i] != out[i]) begin
                            state_d[i] = COUNTING;
                        end
                    end
                    COUNTING: begin
                        if (s[i] == out[i]) begin
                            // Input bounced back: glitch rejected.
                            state_d[i] = STABLE;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == CNT_MAX) begin
                            out_d[i]   = s[i];
                            state_d[i] = STABLE;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_ONE;
                        end
                    end
                endcase
            end
        end
        rise_d = out_d & ~out;
        fall_d = ~out_d & out;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i]  <= {SYNC_STAGES{RESET_LEVEL}};
                state_q[i] <= STABLE;
                cnt_q[i]   <= '0;
            end
            out     <= {CHANNELS{RESET_LEVEL}};
            rise    <= '0;
            fall    <= '0;
            changed <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i]  <= {sync_q[i][SYNC_STAGES-2:0], in[i]};
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            out     <= out_d;
            rise    <= rise_d;
            fall    <= fall_d;
            changed <= |(rise_d | fall_d);
        end
    end

endmodule

// File: tb/tb_debouncer_bank.sv
// tb_debouncer_bank: directed stimulus with a streak-based reference model
// and literal checkpoints for the debouncer bank (4 ch, 4-bit wait, 2 sync).
module tb_debouncer_bank;

    localparam int CH   = 4;
    localparam int WB   = 4;
    localparam int SYNC = 2;
    localparam int WIN  = 1 << WB;

    logic          CLK = 1'b0;
    logic          reset;
    logic          enable;
    logic [CH-1:0] in;
    logic [CH-1:0] out;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic          changed;

    int vectors = 0;
    int miscompares = 0;

    debouncer_bank #(
        .CHANNELS(CH),
        .WAIT_BITS(WB),
        .SYNC_STAGES(SYNC),
        .RESET_LEVEL(1'b0)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .enable(enable),
        .in(in),
        .out(out),
        .rise(rise),
        .fall(fall),
        .changed(changed)
    );

    always #5 CLK = ~CLK;

    // Reference model: the output of a channel flips once the synchronized
    // input has disagreed with it on WIN+1 consecutive edges.
    logic [CH-1:0] m_out;
    logic [CH-1:0] m_rise;
    logic [CH-1:0] m_fall;
    logic          m_changed;
    logic [CH-1:0] m_q [SYNC];
    logic [CH-1:0] m_s;
    logic [CH-1:0] m_nxt;
    int            m_streak [CH];
    bit            model_valid = 0;

    always @(posedge CLK) begin
        if (reset) begin
            for (int k = 0; k < SYNC; k++) m_q[k] = '0;
            for (int c = 0; c < CH; c++) m_streak[c] = 0;
            m_out = '0;
            m_rise = '0;
            m_fall = '0;
            m_changed = 1'b0;
            model_valid = 1;
        end else begin
            m_s = m_q[SYNC-1];
            for (int k = SYNC - 1; k > 0; k--) m_q[k] = m_q[k-1];
            m_q[0] = in;
            m_nxt = m_out;
            for (int c = 0; c < CH; c++) begin
                if (!enable) begin
                    m_nxt[c] = m_s[c];
                    m_streak[c] = 0;
                end else if (m_s[c] == m_out[c]) begin
                    m_streak[c] = 0;
                end else begin
                    m_streak[c] = m_streak[c] + 1;
                    if (m_streak[c] == WIN + 1) begin
                        m_nxt[c] = m_s[c];
                        m_streak[c] = 0;
                    end
                end
            end
            m_rise = m_nxt & ~m_out;
            m_fall = ~m_nxt & m_out;
            m_changed = |(m_rise | m_fall);
            m_out = m_nxt;
        end
    end

    always @(negedge CLK) begin
        if (model_valid) begin
            vectors++;
            if ({out, rise, fall, changed} !== {m_out, m_rise, m_fall, m_changed}) begin
                miscompares++;
                $display("FAIL model_cmp t=%0t out=%h exp %h rise=%h exp %h fall=%h exp %h changed=%b exp %b",
                         $time, out, m_out, rise, m_rise, fall, m_fall, changed, m_changed);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b1;
        in = 4'hF;

        // 1: reset with inputs high, then all channels rise at edge 19
        tick(2);
        check("rst_out", out, 4'h0);
        check("rst_rise", rise, 4'h0);
        check("rst_fall", fall, 4'h0);
        check("rst_changed", {3'b0, changed}, 4'h0);
        reset = 1'b0;
        tick(18);
        check("t1_e18_out", out, 4'h0);
        tick(1);
        check("t1_e19_out", out, 4'hF);
        check("t1_e19_rise", rise, 4'hF);
        check("t1_e19_changed", {3'b0, changed}, 4'h1);
        tick(1);
        check("t1_e20_rise", rise, 4'h0);
        check("t1_e20_changed", {3'b0, changed}, 4'h0);

        // 2: bouncing in[0] is filtered, then a single rise
        in = 4'h0;
        tick(25);
        check("t2_settle0", out, 4'h0);
        for (int seg = 0; seg < 8; seg++) begin
            in[0] = (seg % 2 == 0);
            tick(5);
            check("t2_bounce", out, 4'h0);
        end
        in[0] = 1'b1;
        tick(18);
        check("t2_e18_out", out, 4'h0);
        tick(1);
        check("t2_e19_out", out, 4'h1);
        check("t2_e19_rise", rise, 4'h1);

        // 3: short pulse on in[1] is rejected
        in = 4'b0011;
        tick(15);
        in = 4'b0001;
        tick(25);
        check("t3_out", out, 4'b0001);

        // 4: simultaneous rise on ch1 and fall on ch2
        in = 4'b0100;
        tick(25);
        check("t4_settle", out, 4'b0100);
        in = 4'b0010;
        tick(18);
        check("t4_e18_out", out, 4'b0100);
        tick(1);
        check("t4_e19_out", out, 4'b0010);
        check("t4_e19_rise", rise, 4'b0010);
        check("t4_e19_fall", fall, 4'b0100);
        check("t4_e19_changed", {3'b0, changed}, 4'h1);
        tick(1);
        check("t4_e20_pulses", rise | fall, 4'h0);
        check("t4_e20_changed", {3'b0, changed}, 4'h0);

        // 5: bypass tracks in[3] with 3-edge latency, then filtering resumes
        enable = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in[3] = (k % 2 == 0);
            tick(2);
            check("t5_byp_hold", {3'b0, out[3]}, {3'b0, ~in[3]});
            tick(1);
            check("t5_byp_out", {3'b0, out[3]}, {3'b0, in[3]});
            check("t5_byp_rise", {3'b0, rise[3]}, {3'b0, in[3]});
            check("t5_byp_fall", {3'b0, fall[3]}, {3'b0, ~in[3]});
        end
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in[3] = (k % 2 == 0);
            tick(3);
            check("t5_filt_hold", {3'b0, out[3]}, 4'h0);
        end
        in[3] = 1'b1;
        tick(18);
        check("t5_e18_out", out, 4'b0010);
        tick(1);
        check("t5_e19_out", out, 4'b1010);
        check("t5_e19_rise", rise, 4'b1000);

        // 6: reset mid-count discards the count
        in = 4'b1011;
        tick(13);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t6_rst_out", out, 4'h0);
        check("t6_rst_rise", rise, 4'h0);
        tick(18);
        check("t6_e18_out", out, 4'h0);
        tick(1);
        check("t6_e19_out", out, 4'b1011);
        check("t6_e19_rise", rise, 4'b1011);
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
